// File: rtl/rib_arb_pkg.sv
// RIB interconnect shared definitions: bus widths, address fields, fault record.
package rib_arb_pkg;

    localparam int RIB_AW  = 32;
    localparam int RIB_DW  = 32;
    localparam int IDX_HI  = 31;
    localparam int IDX_LO  = 28;

    typedef enum logic {
        FAULT_PROT   = 1'b0,
        FAULT_DECODE = 1'b1
    } fault_e;

    typedef struct packed {
        logic              valid;
        fault_e            ftype;
        logic [3:0]        master;
        logic [RIB_AW-1:0] addr;
    } fault_t;

    function automatic logic [3:0] slv_idx(input logic [RIB_AW-1:0] a);
        return a[IDX_HI:IDX_LO];
    endfunction

endpackage

// File: rtl/rib_arb_rr_pick.sv
// Round-robin first-one finder: scans mask from ptr upwards with wrap.
module rib_arb_rr_pick #(
    parameter int N  = 6,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW:0] c;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 0; k < N; k++) begin
            c = {1'b0, ptr} + (PW+1)'(k);
            if (c >= (PW+1)'(N)) begin
                c = c - (PW+1)'(N);
            end
            if (!found && mask[c[PW-1:0]]) begin
                found = 1'b1;
                idx   = c[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/rib_arb.sv
// RIB master/slave interconnect with round-robin arbitration, bounded lock
// and TEE access policy with a sticky fault record.
module rib_arb
    import rib_arb_pkg::*;
#(
    parameter int            NM          = 6,
    parameter int            NS          = 6,
    parameter int            MAX_HOLD    = 4,
    parameter logic [NM-1:0] SEC_MASTERS = 6'b000111,
    parameter logic [NS-1:0] SEC_SLAVES  = 6'b000010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM*RIB_AW-1:0] m_addr_i,
    input  logic [NM*RIB_DW-1:0] m_data_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_req_i,
    output logic [NM*RIB_DW-1:0] m_data_o,
    output logic [NM-1:0]        m_hold_o,
    output logic [NM-1:0]        m_err_o,
    output logic [RIB_AW-1:0]    s_addr_o,
    output logic [RIB_DW-1:0]    s_data_o,
    output logic [NS-1:0]        s_we_o,
    input  logic [NS*RIB_DW-1:0] s_data_i,
    output logic                 fault_valid_o,
    output logic                 fault_type_o,
    output logic [3:0]           fault_master_o,
    output logic [RIB_AW-1:0]    fault_addr_o,
    input  logic                 fault_clr_i
);

    localparam int PW = $clog2(NM);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [15:0]   SEC_SL16 = 16'(SEC_SLAVES);

    logic [PW-1:0] ptr;
    logic [PW-1:0] lock_idx;
    logic          lock_v;
    logic [CW-1:0] cnt;
    fault_t        fault;

    logic          expired;
    logic          keep;
    logic [NM-1:0] lock_oh;
    logic [NM-1:0] others;
    logic [NM-1:0] rr_mask;
    logic [PW-1:0] rr_idx;
    logic          rr_found;
    logic [PW-1:0] owner;
    logic          served;
    logic [NM-1:0] own_oh;
    logic [PW-1:0] ptr_next;

    assign expired = lock_v && (cnt == HOLD_MAX);
    assign keep    = lock_v && m_req_i[lock_idx] && (cnt < HOLD_MAX);
    assign lock_oh = NM'(1) << lock_idx;
    assign others  = m_req_i & ~lock_oh;

    // An expired owner is skipped only when someone else is waiting.
    assign rr_mask = (expired && (|others)) ? others : m_req_i;

    rib_arb_rr_pick #(
        .N  (NM),
        .PW (PW)
    ) u_pick (
        .mask  (rr_mask),
        .ptr   (ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

    assign owner    = keep ? lock_idx : rr_idx;
    assign served   = keep || rr_found;
    assign own_oh   = NM'(1) << owner;
    assign ptr_next = (owner == PW'(NM - 1)) ? '0 : owner + PW'(1);

    logic [RIB_AW-1:0] own_addr;
    logic [RIB_DW-1:0] own_wdata;
    logic              own_we;
    logic [3:0]        sidx;
    logic              in_range;
    logic              own_sec;
    logic              slv_sec;
    logic              permit;
    logic              reject;

    assign own_addr  = m_addr_i[int'(owner)*RIB_AW +: RIB_AW];
    assign own_wdata = m_data_i[int'(owner)*RIB_DW +: RIB_DW];
    assign own_we    = m_we_i[owner];
    assign sidx      = slv_idx(own_addr);
    assign in_range  = int'(sidx) < NS;
    assign own_sec   = SEC_MASTERS[owner];
    assign slv_sec   = SEC_SL16[sidx];
    assign permit    = served && in_range && !(slv_sec && !own_sec);
    assign reject    = served && !permit;

    always_comb begin
        m_data_o = '0;
        m_hold_o = '0;
        m_err_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = '0;
        if (served) begin
            s_addr_o = own_addr;
            s_data_o = own_wdata;
            m_hold_o = m_req_i & ~own_oh;
            if (permit) begin
                s_we_o = own_we ? (NS'(1) << sidx) : '0;
                m_data_o[int'(owner)*RIB_DW +: RIB_DW] =
                    s_data_i[int'(sidx)*RIB_DW +: RIB_DW];
            end else begin
                m_err_o = own_oh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            lock_idx <= '0;
            lock_v   <= 1'b0;
            cnt      <= '0;
            fault    <= '0;
        end else begin
            if (served) begin
                lock_v   <= 1'b1;
                lock_idx <= owner;
                if (lock_v && (owner == lock_idx) && (cnt < HOLD_MAX)) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt <= CW'(1);
                end
                if ((owner != lock_idx) || expired) begin
                    ptr <= ptr_next;
                end
            end else begin
                lock_v <= 1'b0;
                cnt    <= '0;
            end
            // A fault arriving with a clear wins, so it is never lost.
            if (reject && (!fault.valid || fault_clr_i)) begin
                fault.valid  <= 1'b1;
                fault.ftype  <= in_range ? FAULT_PROT : FAULT_DECODE;
                fault.master <= 4'(owner);
                fault.addr   <= own_addr;
            end else if (fault_clr_i) begin
                fault.valid <= 1'b0;
            end
        end
    end

    assign fault_valid_o  = fault.valid;
    assign fault_type_o   = fault.ftype;
    assign fault_master_o = fault.master;
    assign fault_addr_o   = fault.addr;

endmodule

// File: tb/tb_rib_arb.sv
// Directed vector bench for rib_arb: arbitration, routing, TEE faults, reset.
module tb_rib_arb;

    localparam logic [31:0] A_ROM  = 32'h0000_0010;
    localparam logic [31:0] A_RAM  = 32'h1000_0004;
    localparam logic [31:0] A_SEC  = 32'h1000_0000;
    localparam logic [31:0] A_BAD  = 32'h7000_0000;
    localparam logic [31:0] D_ROM  = 32'h5A00_0000;
    localparam logic [31:0] D_RAM  = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [191:0] m_addr_i;
    logic [191:0] m_data_i;
    logic [5:0]   m_we_i = '0;
    logic [5:0]   m_req_i = '0;
    logic [191:0] m_data_o;
    logic [5:0]   m_hold_o;
    logic [5:0]   m_err_o;
    logic [31:0]  s_addr_o;
    logic [31:0]  s_data_o;
    logic [5:0]   s_we_o;
    logic [191:0] s_data_i;
    logic         fault_valid_o;
    logic         fault_type_o;
    logic [3:0]   fault_master_o;
    logic [31:0]  fault_addr_o;
    logic         fault_clr_i = 1'b0;
    logic [31:0]  cur_addr = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign m_addr_i = {6{cur_addr}};

    rib_arb dut (
        .clk            (clk),
        .rst            (rst),
        .m_addr_i       (m_addr_i),
        .m_data_i       (m_data_i),
        .m_we_i         (m_we_i),
        .m_req_i        (m_req_i),
        .m_data_o       (m_data_o),
        .m_hold_o       (m_hold_o),
        .m_err_o        (m_err_o),
        .s_addr_o       (s_addr_o),
        .s_data_o       (s_data_o),
        .s_we_o         (s_we_o),
        .s_data_i       (s_data_i),
        .fault_valid_o  (fault_valid_o),
        .fault_type_o   (fault_type_o),
        .fault_master_o (fault_master_o),
        .fault_addr_o   (fault_addr_o),
        .fault_clr_i    (fault_clr_i)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic [5:0]  req;
        logic [5:0]  we;
        logic [31:0] addr;
        int          own;
        logic [5:0]  hold;
        logic [5:0]  err;
        logic [5:0]  swe;
        logic [31:0] rd;
        logic        fv;
        logic        ft;
        logic [3:0]  fm;
        logic [31:0] fa;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        logic r, logic c, logic [5:0] req, logic [5:0] we, logic [31:0] a,
        int own, logic [5:0] hold, logic [5:0] err, logic [5:0] swe,
        logic [31:0] rd, logic fv, logic ft, logic [3:0] fm, logic [31:0] fa
    );
        vec_t v;
        v.rst = r; v.clr = c; v.req = req; v.we = we; v.addr = a;
        v.own = own; v.hold = hold; v.err = err; v.swe = swe; v.rd = rd;
        v.fv = fv; v.ft = ft; v.fm = fm; v.fa = fa;
        return v;
    endfunction

    task automatic chk(input string name, input int k,
                       input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", name, k, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int k);
        logic [191:0] e_md;
        logic [31:0]  e_sa;
        logic [31:0]  e_sd;
        @(negedge clk);
        rst         = v.rst;
        fault_clr_i = v.clr;
        m_req_i     = v.req;
        m_we_i      = v.we;
        cur_addr    = v.addr;
        e_md = '0;
        e_sa = '0;
        e_sd = '0;
        if (v.own >= 0) begin
            e_md[v.own*32 +: 32] = v.rd;
            e_sa = v.addr;
            e_sd = 32'h0C0C_0000 | 32'(v.own);
        end
        #2;
        chk("hold", k, 192'(m_hold_o), 192'(v.hold));
        chk("err", k, 192'(m_err_o), 192'(v.err));
        chk("s_we", k, 192'(s_we_o), 192'(v.swe));
        chk("s_addr", k, 192'(s_addr_o), 192'(e_sa));
        chk("s_data", k, 192'(s_data_o), 192'(e_sd));
        chk("m_data", k, m_data_o, e_md);
        @(posedge clk);
        #1;
        chk("fault", k,
            192'({fault_valid_o, fault_type_o, fault_master_o, fault_addr_o}),
            192'({v.fv, v.ft, v.fm, v.fa}));
    endtask

    int exp_own[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

    initial begin
        for (int i = 0; i < 6; i++) begin
            m_data_i[i*32 +: 32] = 32'h0C0C_0000 | 32'(i);
            s_data_i[i*32 +: 32] = (i == 1) ? D_RAM : (D_ROM | 32'(i));
        end

        tv.push_back(mk(1,0,6'h00,6'h00,32'h0,-1,6'h00,6'h00,6'h00,0,0,0,0,0));
        tv.push_back(mk(0,0,6'h01,6'h00,A_RAM,0,6'h00,6'h00,6'h00,D_RAM,0,0,0,0));
        tv.push_back(mk(0,0,6'h01,6'h01,A_RAM,0,6'h00,6'h00,6'h02,D_RAM,0,0,0,0));
        tv.push_back(mk(1,0,6'h00,6'h00,32'h0,-1,6'h00,6'h00,6'h00,0,0,0,0,0));
        for (int i = 0; i < 9; i++) begin
            if (i >= 4 && i < 8)
                tv.push_back(mk(0,0,6'h12,6'h00,A_ROM,4,6'h02,0,0,D_ROM,0,0,0,0));
            else
                tv.push_back(mk(0,0,6'h12,6'h00,A_ROM,1,6'h10,0,0,D_ROM,0,0,0,0));
        end
        tv.push_back(mk(1,0,6'h00,6'h00,32'h0,-1,6'h00,6'h00,6'h00,0,0,0,0,0));
        for (int i = 0; i < 10; i++)
            tv.push_back(mk(0,0,6'h02,6'h00,A_ROM,1,6'h00,0,0,D_ROM,0,0,0,0));
        tv.push_back(mk(0,0,6'h05,6'h00,A_ROM,2,6'h01,0,0,D_ROM,0,0,0,0));
        tv.push_back(mk(1,0,6'h00,6'h00,32'h0,-1,6'h00,6'h00,6'h00,0,0,0,0,0));
        tv.push_back(mk(0,0,6'h08,6'h08,A_SEC,3,6'h00,6'h08,0,0,1,0,3,A_SEC));
        tv.push_back(mk(0,0,6'h10,6'h00,A_SEC,4,6'h00,6'h10,0,0,1,0,3,A_SEC));
        tv.push_back(mk(0,0,6'h01,6'h00,A_BAD,0,6'h00,6'h01,0,0,1,0,3,A_SEC));
        tv.push_back(mk(0,1,6'h01,6'h00,A_BAD,0,6'h00,6'h01,0,0,1,1,0,A_BAD));
        tv.push_back(mk(0,1,6'h00,6'h00,32'h0,-1,6'h00,6'h00,0,0,0,1,0,A_BAD));
        tv.push_back(mk(0,0,6'h01,6'h00,A_BAD,0,6'h00,6'h01,0,0,1,1,0,A_BAD));
        for (int i = 0; i < 3; i++)
            tv.push_back(mk(0,0,6'h04,6'h00,A_ROM,2,6'h00,0,0,D_ROM,1,1,0,A_BAD));
        tv.push_back(mk(1,0,6'h05,6'h00,A_ROM,2,6'h01,0,0,D_ROM,0,0,0,0));
        tv.push_back(mk(0,0,6'h05,6'h00,A_ROM,0,6'h04,0,0,D_ROM,0,0,0,0));

        rst = 1'b1;
        repeat (2) @(posedge clk);

        foreach (tv[k]) apply(tv[k], k);

        // Three masters contending: each keeps the grant for MAX_HOLD cycles.
        @(negedge clk);
        rst = 1'b1;
        m_req_i = '0;
        @(negedge clk);
        rst = 1'b0;
        m_req_i = 6'h07;
        m_we_i = '0;
        cur_addr = A_ROM;
        for (int c = 0; c < 12; c++) begin
            #2;
            chk("rr3_hold", 100 + c, 192'(m_hold_o),
                192'(6'h07 & ~(6'h01 << exp_own[c])));
            chk("rr3_err", 100 + c, 192'(m_err_o), 192'(6'h00));
            @(negedge clk);
        end

        m_req_i = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
